// File: rtl/decode_stage.sv
// decode_stage -- pipelined instruction-decode stage between fetch and execute.
//
// Each accepted instruction word is split into fields, classified into an
// encoding class, expanded into a sign-extended immediate and a control word,
// and registered together with the register-file operands. Valid/ready
// handshakes run on both sides. A load-use hazard against the instruction held
// in the output register stalls the input side for one cycle. Flush discards
// the held instruction and refuses the offered one.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     fetch-side handshake
//   in_pc, in_instr         offered instruction address and word
//   flush                   discard held and offered instruction
//   rs1_addr, rs2_addr      register-file read addresses (combinational)
//   rs1_data, rs2_data      register-file read data (same cycle)
//   out_valid / out_ready   execute-side handshake
//   out_pc, out_rs1_data,
//   out_rs2_data, out_imm   registered payload
//   out_control             registered control word
//   out_illegal             registered: held instruction was unsupported

package decode_pkg;

  // Zero values of both enums are the ones an illegal instruction reports.
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } encoding_t;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  typedef struct packed {
    encoding_t  encoding;
    alu_op_t    alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       reg_write;
    logic [4:0] write_back_id;
  } control_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

module decode_stage
  import decode_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_pc,
  input  instruction_t in_instr,
  input  logic         flush,
  output logic [4:0]   rs1_addr,
  output logic [4:0]   rs2_addr,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_pc,
  output logic [31:0]  out_rs1_data,
  output logic [31:0]  out_rs2_data,
  output logic [31:0]  out_imm,
  output control_t     out_control,
  output logic         out_illegal
);

  logic [31:0] instr_w;
  control_t    dec_ctrl;
  logic [31:0] dec_imm;
  logic        dec_legal;
  logic        use_rs1;
  logic        use_rs2;
  logic        hazard;
  logic        accept;
  logic [4:0]  held_wb;

  assign instr_w  = in_instr;
  assign rs1_addr = in_instr.rs1;
  assign rs2_addr = in_instr.rs2;

  // Decode: classify, build control word and immediate.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    dec_ctrl  = '0;
    dec_imm   = '0;
    dec_legal = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;

    unique case (in_instr.opcode)
      OP_R: begin
        dec_ctrl.encoding  = R_TYPE;
        dec_ctrl.reg_write = 1'b1;
        dec_legal          = 1'b1;
        if (in_instr.funct7 == 7'b0000000) begin
          unique case (in_instr.funct3)
            3'b000:  dec_ctrl.alu_op = ALU_ADD;
            3'b110:  dec_ctrl.alu_op = ALU_OR;
            3'b111:  dec_ctrl.alu_op = ALU_AND;
            default: dec_legal = 1'b0;
          endcase
        end else if (in_instr.funct7 == 7'b0100000 && in_instr.funct3 == 3'b000) begin
          dec_ctrl.alu_op = ALU_SUB;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_IMM: begin
        dec_ctrl.encoding  = I_TYPE;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_legal          = 1'b1;
        unique case (in_instr.funct3)
          3'b000:  dec_ctrl.alu_op = ALU_ADD;
          3'b110:  dec_ctrl.alu_op = ALU_OR;
          3'b111:  dec_ctrl.alu_op = ALU_AND;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec_ctrl.encoding  = I_TYPE;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_read  = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_legal          = (in_instr.funct3 == 3'b010);
      end
      OP_STORE: begin
        dec_ctrl.encoding  = S_TYPE;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_legal          = (in_instr.funct3 == 3'b010);
      end
      OP_BRANCH: begin
        dec_ctrl.encoding  = B_TYPE;
        dec_ctrl.is_branch = 1'b1;
        dec_ctrl.alu_op    = ALU_SUB;
        dec_legal          = (in_instr.funct3 == 3'b000);
      end
      OP_LUI: begin
        dec_ctrl.encoding  = U_TYPE;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_legal          = 1'b1;
      end
      OP_JAL: begin
        dec_ctrl.encoding  = J_TYPE;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.is_branch = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_legal          = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      // Unsupported words flow through with an all-zero control word.
      dec_ctrl = '0;
    end else begin
      if (dec_ctrl.reg_write) dec_ctrl.write_back_id = in_instr.rd;

      unique case (dec_ctrl.encoding)
        I_TYPE:  dec_imm = {{20{instr_w[31]}}, instr_w[31:20]};
        S_TYPE:  dec_imm = {{20{instr_w[31]}}, instr_w[31:25], instr_w[11:7]};
        B_TYPE:  dec_imm = {{19{instr_w[31]}}, instr_w[31], instr_w[7],
                            instr_w[30:25], instr_w[11:8], 1'b0};
        U_TYPE:  dec_imm = {instr_w[31:12], 12'b0};
        J_TYPE:  dec_imm = {{11{instr_w[31]}}, instr_w[31], instr_w[19:12],
                            instr_w[20], instr_w[30:21], 1'b0};
        default: dec_imm = '0;
      endcase

      // Illegal words read no operands, so they never stall on a load.
      use_rs1 = (dec_ctrl.encoding inside {R_TYPE, I_TYPE, S_TYPE, B_TYPE});
      use_rs2 = (dec_ctrl.encoding inside {R_TYPE, S_TYPE, B_TYPE});
    end
  end

  // Load-use: the held load's result is not yet in the register file, so the
  // offered instruction waits until the load has moved on to execute.
  assign held_wb = out_control.write_back_id;
  assign hazard  = out_valid && out_control.mem_read && (held_wb != 5'd0) &&
                   ((use_rs1 && held_wb == in_instr.rs1) ||
                    (use_rs2 && held_wb == in_instr.rs2));

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is reset too (not only out_valid) because execute
      // and observers see all-zero outputs straight out of reset.
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_control  <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_imm      <= dec_imm;
      out_control  <= dec_ctrl;
      out_illegal  <= !dec_legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
